enc_dec_pipe: RTL and testbench
===============================

ENC_DEC_PIPE -- requirements
Module: enc_dec_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning input/output vector width; legal values 4, 8, 16, 32.
REQ-002 The block SHALL have parameter IDX_W, default 3, meaning index width, equal to log2(WIDTH).
REQ-003 The block SHALL have port Clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port Rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port In, input, WIDTH, the vector to encode.
REQ-006 The block SHALL have port In_valid, input, 1, meaning In is presented.
REQ-007 The block SHALL have port In_ready, output, 1, meaning the block accepts In this cycle.
REQ-008 The block SHALL have port Out, output, WIDTH, the one-hot decode of Index (all zero when Zero=1).
REQ-009 The block SHALL have port Index, output, IDX_W, the position of the highest set bit of In.
REQ-010 The block SHALL have port Zero, output, 1, meaning In was all zeros.
REQ-011 The block SHALL have port Multi, output, 1, meaning In had more than one bit set.
REQ-012 The block SHALL have port Out_valid, output, 1, meaning Out/Index/Zero/Multi hold a result.
REQ-013 The block SHALL have port Out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-014 When ENC_DEC_ERRCNT_EN is defined, the block SHALL have port Err_cnt, output, 16, the saturating count of Multi results.

Function
REQ-015 A transfer in SHALL occur on a rising Clk edge where In_valid=1 and In_ready=1.
REQ-016 A transfer out SHALL occur on a rising Clk edge where Out_valid=1 and Out_ready=1.
REQ-017 The block SHALL be a two-stage pipeline: S1 registers Index, Zero and Multi from In; S2 registers the decode of S1 into Out along with copies of Index, Zero and Multi.
REQ-018 The latency from an accepted In to Out_valid=1 SHALL be 2 cycles when Out_ready is held at 1.
REQ-019 Encoding SHALL give priority to the highest bit: Index is the largest i with In[i]=1.
REQ-020 When In=0, S1 SHALL produce Index=0, Zero=1 and Multi=0, and S2 SHALL produce Out=0.
REQ-021 Multi SHALL be 1 exactly when the population count of In is at least 2.
REQ-022 Out SHALL equal 1 shifted left by Index when Zero=0.
REQ-023 S2 SHALL load from S1 when S2 is empty or a transfer out occurs in the same cycle.
REQ-024 S1 SHALL load from In when S1 is empty or S1 moves to S2 in the same cycle.
REQ-025 In_ready SHALL equal (S1 empty) OR (S2 empty) OR Out_ready, computed combinationally with no registered bubble.
REQ-026 Under sustained backpressure (Out_ready=0), both stages SHALL fill, In_ready SHALL fall to 0, and no result SHALL be lost or duplicated.
REQ-027 Throughput SHALL be one result per cycle when In_valid=1 and Out_ready=1 continuously.
REQ-028 S2 outputs SHALL stay stable while Out_valid=1 and Out_ready=0.
REQ-029 Results SHALL leave the block in the same order their inputs were accepted.

Reset
REQ-030 While Rst_n=0 at a rising edge, both stage valid flags SHALL clear, and Out=0, Index=0, Zero=0, Multi=0 and Out_valid=0.
REQ-031 In_ready SHALL be 0 during reset and 1 in the first cycle after Rst_n returns to 1.
REQ-032 A reset asserted mid-operation SHALL discard in-flight results, with no partial transfer out.

Configuration
REQ-033 With ENC_DEC_ERRCNT_EN defined, Err_cnt SHALL increment on each transfer out with Multi=1, saturate at 16'hFFFF, and reset to 0.
REQ-034 Without ENC_DEC_ERRCNT_EN, the Err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 WIDTH=8, Out_ready=1, walk In through 1, 2, 4, ..., 128, one per cycle: Out equals In with Index 0..7, results 2 cycles after each input, back to back.
REQ-036 In=8'h00 -> Zero=1, Out=0, Index=0, Multi=0.
REQ-037 In=8'b0101_0010 -> Index=6, Out=8'h40, Multi=1; with ENC_DEC_ERRCNT_EN defined, Err_cnt increments by 1.
REQ-038 Stream of 4 inputs with Out_ready=0 for 5 cycles, then Out_ready=1: In_ready falls after 2 accepts, and all 4 results emerge in order, exactly once.
REQ-039 Assert Rst_n=0 with both stages full: next cycle Out_valid=0 and all outputs are zero; after release, the first new input emerges after 2 cycles.
REQ-040 WIDTH=16, In=16'h8001 -> Index=15, Out=16'h8000, Multi=1.

Source files
------------

// File: rtl/enc_dec_pipe.sv
// enc_dec_pipe: two-stage priority encoder / one-hot decoder with a
// valid/ready handshake on both sides.
//   S1 registers Index/Zero/Multi of the incoming vector.
//   S2 registers the one-hot decode of S1 plus copies of its flags.
// Optional feature macro: ENC_DEC_ERRCNT_EN adds a 16-bit saturating
// Err_cnt output counting results delivered with Multi=1.
module enc_dec_pipe #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] In,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Out,
    output logic [IDX_W-1:0] Index,
    output logic             Zero,
    output logic             Multi,
    output logic             Out_valid,
    input  logic             Out_ready
`ifdef ENC_DEC_ERRCNT_EN
    ,
    output logic [15:0]      Err_cnt
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             s1_vld_q, s1_vld_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic             s1_zero_q, s1_zero_d;
    logic             s1_multi_q, s1_multi_d;

    logic             s2_vld_q, s2_vld_d;
    logic [WIDTH-1:0] s2_out_q, s2_out_d;
    logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_multi_q, s2_multi_d;

    logic             xfer_out;
    logic             s2_load;
    logic             s1_load;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_zero;
    logic             enc_multi;

    // Priority encode: the highest set bit wins; Multi when two or more bits are set.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (In[i]) enc_idx = IDX_W'(i);
        end
        enc_zero  = (In == '0);
        enc_multi = ((In & (In - ONE)) != '0);
    end

    // Handshake: a stage loads when it is empty or its content moves on this cycle.
    always_comb begin
        xfer_out = s2_vld_q & Out_ready;
        s2_load  = ~s2_vld_q | xfer_out;
        s1_load  = ~s1_vld_q | s2_load;
        // Gated by Rst_n so the block never advertises space while held in reset.
        In_ready = Rst_n & s1_load;
    end

    // Next-state for both stages; the decode is done from S1's registered index.
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_idx_d   = s1_idx_q;
        s1_zero_d  = s1_zero_q;
        s1_multi_d = s1_multi_q;
        s2_vld_d   = s2_vld_q;
        s2_out_d   = s2_out_q;
        s2_idx_d   = s2_idx_q;
        s2_zero_d  = s2_zero_q;
        s2_multi_d = s2_multi_q;
        if (s2_load) begin
            s2_vld_d   = s1_vld_q;
            s2_out_d   = s1_zero_q ? '0 : (ONE << s1_idx_q);
            s2_idx_d   = s1_idx_q;
            s2_zero_d  = s1_zero_q;
            s2_multi_d = s1_multi_q;
        end
        if (s1_load) begin
            s1_vld_d   = In_valid;
            s1_idx_d   = enc_idx;
            s1_zero_d  = enc_zero;
            s1_multi_d = enc_multi;
        end
    end

    // Pipeline registers with synchronous active-low reset that drops in-flight data.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_idx_q   <= '0;
            s1_zero_q  <= 1'b0;
            s1_multi_q <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_out_q   <= '0;
            s2_idx_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_multi_q <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_idx_q   <= s1_idx_d;
            s1_zero_q  <= s1_zero_d;
            s1_multi_q <= s1_multi_d;
            s2_vld_q   <= s2_vld_d;
            s2_out_q   <= s2_out_d;
            s2_idx_q   <= s2_idx_d;
            s2_zero_q  <= s2_zero_d;
            s2_multi_q <= s2_multi_d;
        end
    end

    assign Out       = s2_out_q;
    assign Index     = s2_idx_q;
    assign Zero      = s2_zero_q;
    assign Multi     = s2_multi_q;
    assign Out_valid = s2_vld_q;

`ifdef ENC_DEC_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Count delivered multi-bit results, holding at all-ones.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            err_cnt_q <= 16'd0;
        end else if (xfer_out && s2_multi_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign Err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_enc_dec_pipe.sv
// Directed bench for enc_dec_pipe: an 8-bit instance for the main checks and
// a 16-bit instance for the wide-vector case.
module tb_enc_dec_pipe;

    logic        clk;
    logic        rst_n;

    logic [7:0]  in8;
    logic        in8_valid;
    logic        in8_ready;
    logic [7:0]  out8;
    logic [2:0]  idx8;
    logic        zero8;
    logic        multi8;
    logic        out8_valid;
    logic        out8_ready;

    logic [15:0] in16;
    logic        in16_valid;
    logic        in16_ready;
    logic [15:0] out16;
    logic [3:0]  idx16;
    logic        zero16;
    logic        multi16;
    logic        out16_valid;
    logic        out16_ready;

`ifdef ENC_DEC_ERRCNT_EN
    logic [15:0] err8;
    logic [15:0] err16;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    enc_dec_pipe #(.WIDTH(8), .IDX_W(3)) u_dut8 (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .In        (in8),
        .In_valid  (in8_valid),
        .In_ready  (in8_ready),
        .Out       (out8),
        .Index     (idx8),
        .Zero      (zero8),
        .Multi     (multi8),
        .Out_valid (out8_valid),
        .Out_ready (out8_ready)
`ifdef ENC_DEC_ERRCNT_EN
        ,
        .Err_cnt   (err8)
`endif
    );

    enc_dec_pipe #(.WIDTH(16), .IDX_W(4)) u_dut16 (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .In        (in16),
        .In_valid  (in16_valid),
        .In_ready  (in16_ready),
        .Out       (out16),
        .Index     (idx16),
        .Zero      (zero16),
        .Multi     (multi16),
        .Out_valid (out16_valid),
        .Out_ready (out16_ready)
`ifdef ENC_DEC_ERRCNT_EN
        ,
        .Err_cnt   (err16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one vector, then idle; afterwards the result sits in S2.
    task automatic send8(input logic [7:0] v);
        in8       = v;
        in8_valid = 1'b1;
        step();
        in8_valid = 1'b0;
        step();
    endtask

    logic [7:0] bp_vec [4];
    logic [7:0] bp_exp [4];
    logic [7:0] bp_got [4];
    int         acc;
    int         ncol;

    initial begin
        rst_n       = 1'b0;
        in8         = '0;
        in8_valid   = 1'b0;
        out8_ready  = 1'b1;
        in16        = '0;
        in16_valid  = 1'b0;
        out16_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_out_valid", out8_valid, 0);
        check("rst_out",       out8,       0);
        check("rst_index",     idx8,       0);
        check("rst_zero",      zero8,      0);
        check("rst_multi",     multi8,     0);
        check("rst_in_ready",  in8_ready,  0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in8_ready, 1);

        // Walking one, back to back, result one edge after acceptance edge +1
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                in8       = 8'(1 << i);
                in8_valid = 1'b1;
            end else begin
                in8_valid = 1'b0;
            end
            step();
            if (i == 0) begin
                check("walk_first_not_valid", out8_valid, 0);
            end else begin
                check($sformatf("walk_valid_%0d", i - 1), out8_valid, 1);
                check($sformatf("walk_out_%0d",   i - 1), out8,       32'(1 << (i - 1)));
                check($sformatf("walk_index_%0d", i - 1), idx8,       32'(i - 1));
                check($sformatf("walk_multi_%0d", i - 1), multi8,     0);
            end
        end

        // All-zero input
        send8(8'h00);
        check("zero_valid", out8_valid, 1);
        check("zero_zero",  zero8,      1);
        check("zero_out",   out8,       0);
        check("zero_index", idx8,       0);
        check("zero_multi", multi8,     0);

        // Multi-bit input: highest bit wins
        send8(8'b0101_0010);
        check("multi_valid", out8_valid, 1);
        check("multi_index", idx8,       6);
        check("multi_out",   out8,       8'h40);
        check("multi_multi", multi8,     1);
        check("multi_zero",  zero8,      0);
        step();
        check("multi_drained", out8_valid, 0);
`ifdef ENC_DEC_ERRCNT_EN
        check("errcnt_after_multi", err8, 1);
`endif

        // Backpressure: 4 inputs, Out_ready low for 5 cycles
        bp_vec[0] = 8'h03; bp_exp[0] = 8'h02;
        bp_vec[1] = 8'h10; bp_exp[1] = 8'h10;
        bp_vec[2] = 8'h80; bp_exp[2] = 8'h80;
        bp_vec[3] = 8'h01; bp_exp[3] = 8'h01;
        acc  = 0;
        ncol = 0;
        for (int c = 0; c < 20; c++) begin
            out8_ready = (c >= 5);
            if (acc < 4) begin
                in8       = bp_vec[acc];
                in8_valid = 1'b1;
            end else begin
                in8_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                check("bp_in_ready_low", in8_ready, 0);
                check("bp_accepts",      acc,       2);
            end
            if (c == 4) begin
                check("bp_hold_valid", out8_valid, 1);
                check("bp_hold_out",   out8,       8'h02);
                check("bp_hold_index", idx8,       1);
            end
            if (in8_valid && in8_ready) acc++;
            if (out8_valid && out8_ready) begin
                if (ncol < 4) bp_got[ncol] = out8;
                ncol++;
            end
            @(posedge clk);
            #1;
        end
        in8_valid = 1'b0;
        check("bp_accept_count", acc,  4);
        check("bp_result_count", ncol, 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_order_%0d", k), bp_got[k], bp_exp[k]);
        end
`ifdef ENC_DEC_ERRCNT_EN
        check("errcnt_after_bp", err8, 2);
`endif

        // Mid-operation reset with both stages full
        out8_ready = 1'b0;
        in8        = 8'h04;
        in8_valid  = 1'b1;
        step();
        in8        = 8'h20;
        step();
        in8_valid  = 1'b0;
        check("full_valid", out8_valid, 1);
        check("full_out",   out8,       8'h04);
        rst_n = 1'b0;
        step();
        check("midrst_valid", out8_valid, 0);
        check("midrst_out",   out8,       0);
        check("midrst_index", idx8,       0);
        check("midrst_zero",  zero8,      0);
        check("midrst_multi", multi8,     0);
`ifdef ENC_DEC_ERRCNT_EN
        check("midrst_errcnt", err8, 0);
`endif
        rst_n      = 1'b1;
        out8_ready = 1'b1;
        in8        = 8'h08;
        in8_valid  = 1'b1;
        #1;
        check("postrst_in_ready", in8_ready, 1);
        step();
        in8_valid = 1'b0;
        check("postrst_not_yet", out8_valid, 0);
        step();
        check("postrst_valid", out8_valid, 1);
        check("postrst_out",   out8,       8'h08);
        check("postrst_index", idx8,       3);
        step();
        check("postrst_once", out8_valid, 0);

        // 16-bit instance
        in16       = 16'h8001;
        in16_valid = 1'b1;
        step();
        in16_valid = 1'b0;
        step();
        check("w16_valid", out16_valid, 1);
        check("w16_index", idx16,       15);
        check("w16_out",   out16,       16'h8000);
        check("w16_multi", multi16,     1);
        check("w16_zero",  zero16,      0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
